fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the control unit: owns the PC,

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/npc_gen.sv | 48 ++++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : cpu_types_pkg                                                    |
// | Brief  : Shared types and constants for the fetch stage and its helpers.  |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef logic [1:0] jump_sel_t;

  localparam jump_sel_t JMP_NONE = 2'd0;
  localparam jump_sel_t JMP_REG  = 2'd1;
  localparam jump_sel_t JMP_DIR  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/npc_gen.sv
// +--------------------------------------------------------------------------+
// | Module : npc_gen                                                          |
// | Brief  : Combinational next-PC selection (JR, J/JAL, branch, sequential). |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module npc_gen
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              PCSrc,
  input  logic [1:0]        Jump,
  input  logic [WORD_W-1:0] rs_data,
  output logic [WORD_W-1:0] npc,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] w_br_off;
  logic [WORD_W-1:0] w_jmp_dir;
  logic [WORD_W-1:0] w_jmp_reg;
  logic              w_unused_bits;

  assign npc       = pc + WORD_W'(4);
  assign w_br_off  = {{(WORD_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign w_jmp_dir = {npc[WORD_W-1:28], instr[25:0], 2'b00};
  assign w_jmp_reg = {rs_data[WORD_W-1:2], 2'b00};

  // Opcode bits and the low register-target bits never affect the target.
  assign w_unused_bits = ^{instr[WORD_W-1:26], rs_data[1:0]};

  always_comb begin
    next_pc = npc;
    if (Jump == JMP_REG) begin
      next_pc = w_jmp_reg;
    end else if (Jump == JMP_DIR) begin
      next_pc = w_jmp_dir;
    end else if (!PCSrc) begin
      next_pc = npc + w_br_off;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | Module : fetch_stage                                                      |
// | Brief  : Owns the PC, fetches one instruction at a time, holds it for     |
// |          decode and redirects on jump/branch; stops permanently on halt.  |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] npc,
  input  logic              advance,
  input  logic              PCSrc,
  input  logic [1:0]        Jump,
  input  logic [WORD_W-1:0] rs_data,
  input  logic              halt
);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] w_next_pc;

  npc_gen #(
    .WORD_W (WORD_W)
  ) u_npc_gen (
    .pc      (r_pc),
    .instr   (r_instr),
    .PCSrc   (PCSrc),
    .Jump    (Jump),
    .rs_data (rs_data),
    .npc     (npc),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_pc    <= WORD_W'(PC_INIT);
      r_instr <= '0;
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (ihit) begin
            r_instr <= iload;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Halt wins over any redirect and freezes the PC on the halting instruction.
          if (advance) begin
            if (halt) begin
              r_state <= HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= FETCH;
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Gated by nRST so nothing is requested or presented while reset is held.
  assign iREN        = nRST && (r_state == FETCH);
  assign instr_valid = nRST && (r_state == HOLD);
  assign iaddr       = {r_pc[WORD_W-1:2], 2'b00};
  assign pc          = r_pc;
  assign instr       = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | Module : tb_fetch_stage                                                   |
// | Brief  : Directed and random checks of fetch_stage against a behavioural  |
// |          model of the fetch/hold/halt protocol and next-PC rules.         |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;
  import cpu_types_pkg::*;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST, ihit, advance, PCSrc, halt;
  logic [31:0] iload, rs_data;
  logic [1:0]  Jump;
  logic        iREN, instr_valid;
  logic [31:0] iaddr, instr, pc, npc;

  fetch_stage #(
    .PC_INIT (PC_INIT),
    .WORD_W  (32)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .npc         (npc),
    .advance     (advance),
    .PCSrc       (PCSrc),
    .Jump        (Jump),
    .rs_data     (rs_data),
    .halt        (halt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the fetch stage currently owns.
  logic [31:0] m_pc, m_instr;
  bit          m_holding, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_target();
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    if (Jump == 2'd1) return rs_data & 32'hFFFF_FFFC;
    if (Jump == 2'd2) return (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    if (!PCSrc) begin
      off = $signed(m_instr[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic step();
    @(posedge CLK);
    if (!nRST) begin
      m_pc = PC_INIT; m_instr = 32'h0; m_holding = 0; m_halted = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (!m_holding) begin
      if (ihit) begin m_instr = iload; m_holding = 1; end
    end else if (advance) begin
      if (halt) begin m_halted = 1; m_holding = 0; end
      else begin m_pc = ref_target(); m_holding = 0; end
    end
    #1;
    check("iREN",        32'(iREN),        32'(nRST && !m_holding && !m_halted));
    check("instr_valid", 32'(instr_valid), 32'(nRST && m_holding));
    check("iaddr",       iaddr,            m_pc);
    check("pc",          pc,               m_pc);
    check("instr",       instr,            m_instr);
    check("npc",         npc,              m_pc + 32'd4);
  endtask

  task automatic fetch_issue(input logic [31:0] word);
    ihit = 1'b1; iload = word; advance = 1'b0; halt = 1'b0;
    step();
  endtask

  task automatic adv(input logic src, input logic [1:0] jmp, input logic [31:0] rs, input logic hlt);
    ihit = 1'b0; advance = 1'b1; PCSrc = src; Jump = jmp; rs_data = rs; halt = hlt;
    step();
    advance = 1'b0; halt = 1'b0;
  endtask

  initial begin
    int k;
    nRST = 1'b0; ihit = 1'b0; advance = 1'b0; PCSrc = 1'b1; Jump = 2'd0;
    rs_data = 32'h0; halt = 1'b0; iload = 32'h0;
    m_pc = PC_INIT; m_instr = 32'h0; m_holding = 0; m_halted = 0;

    // Reset, then back-to-back sequential fetches with ihit and advance always high
    ihit = 1'b1; advance = 1'b1;
    for (int i = 0; i < 3; i++) begin iload = $urandom; step(); end
    nRST = 1'b1;
    k = 0;
    check("seq_first", iaddr, 32'h0);
    for (int i = 0; i < 12; i++) begin
      iload = $urandom;
      step();
      if (iREN) begin
        k++;
        check("seq_addr", iaddr, 32'(k * 4));
      end
    end

    // Backward branch from 0x40
    nRST = 1'b0; step(); nRST = 1'b1;
    fetch_issue(32'h0);
    adv(1'b1, 2'd1, 32'h0000_0040, 1'b0);
    fetch_issue(32'h1000_FFFE);
    adv(1'b0, 2'd0, 32'h0, 1'b0);
    check("br_back", iaddr, 32'h0000_003C);

    // Direct jump keeps the region bits, register jump clears the low bits
    fetch_issue(32'h0);
    adv(1'b1, 2'd1, 32'h1000_0000, 1'b0);
    fetch_issue(32'h0800_0100);
    adv(1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0);
    check("j_dir", iaddr, 32'h1000_0400);
    fetch_issue(32'h0);
    adv(1'b1, 2'd1, 32'h0000_0123, 1'b0);
    check("j_reg", iaddr, 32'h0000_0120);

    // Stall in HOLD
    fetch_issue(32'hDEAD_BEEF);
    PCSrc = 1'b1; Jump = 2'd0;
    for (int i = 0; i < 5; i++) begin ihit = 1'b1; iload = $urandom; advance = 1'b0; step(); end
    check("stall_instr", instr, 32'hDEAD_BEEF);
    check("stall_pc",    pc,    32'h0000_0120);
    adv(1'b1, 2'd0, 32'h0, 1'b0);
    check("stall_next",  iaddr, 32'h0000_0124);

    // Halt overrides a direct jump and is permanent
    fetch_issue(32'h0800_0100);
    adv(1'b1, 2'd2, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin ihit = 1'b1; advance = 1'b1; iload = $urandom; step(); end
    check("halt_iren", 32'(iREN), 32'h0);
    check("halt_pc",   pc,        32'h0000_0124);

    // Reset during FETCH with a coincident ihit, then PC wrap
    nRST = 1'b0; step(); nRST = 1'b1;
    ihit = 1'b0; step();
    nRST = 1'b0; ihit = 1'b1; iload = 32'hCAFE_F00D; step();
    check("rst_instr", instr,              32'h0);
    check("rst_valid", 32'(instr_valid),   32'h0);
    check("rst_pc",    pc,                 PC_INIT);
    nRST = 1'b1;
    fetch_issue(32'h0);
    adv(1'b1, 2'd1, 32'hFFFF_FFFC, 1'b0);
    fetch_issue(32'h0);
    adv(1'b1, 2'd0, 32'h0, 1'b0);
    check("wrap", iaddr, 32'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      nRST    = ($urandom_range(0, 59) != 0);
      if (m_halted && $urandom_range(0, 7) == 0) nRST = 1'b0;
      ihit    = ($urandom_range(0, 2) != 0);
      iload   = $urandom;
      advance = ($urandom_range(0, 1) != 0);
      PCSrc   = ($urandom_range(0, 1) != 0);
      Jump    = 2'($urandom_range(0, 3));
      rs_data = $urandom;
      halt    = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
